ps2_keycode_rx: RTL and testbench
=================================

Name: ps2_keycode_rx

Overview:
Receives PS/2 keyboard frames (scan code set 2) from the board pins and produces the 8-bit `keycode` bus that game logic consumes. The bus uses USB HID usage codes: 0x07 D, 0x1A W, 0x04 A, 0x16 S. The block handles make, break (F0) and extended (E0) prefixes, and holds `keycode` non-zero while a mapped key is down. It replaces the host-supplied keycode path so the game runs standalone from a PS/2 keyboard.

Parameters:
- SYNC_STAGES, 2, flops in the synchronizer on each of ps2_clk and ps2_data (minimum 2).
- TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge before a partial frame is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- keycode  out  8  HID code of the currently held mapped key; 0 when none
- key_valid  out  1  one-cycle pulse when keycode changes to a non-zero value
- scan_code  out  8  last correctly received raw byte
- scan_strobe  out  1  one-cycle pulse when scan_code updates
- frame_err  out  1  one-cycle pulse on start, parity or stop error, or on timeout

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, break/ext flags cleared, synchronizers cleared to 1. Reset mid-frame discards the partial frame with no frame_err.
- Input sync: both pins pass through SYNC_STAGES flops. A falling edge is synchronized previous = 1 and current = 0, registered once more. Edge is detected SYNC_STAGES+1 cycles after the pin edge.
- Bits are sampled only on a detected falling edge, in this order:
  - start bit, must be 0
  - 8 data bits, LSB first
  - parity bit, odd parity over data + parity
  - stop bit, must be 1
- FSM: IDLE -> DATA (start = 0) -> PARITY (after 8 bits, 3-bit counter) -> STOP -> IDLE.
  - Start = 1 in IDLE: stay in IDLE, no error.
- Stop bit sampled:
  - Good frame: scan_code <= byte and scan_strobe = 1 in the following cycle.
  - Parity or stop error: frame_err = 1, scan_code unchanged.
- Timeout: a counter resets on every detected edge and counts in any non-IDLE state. On reaching TIMEOUT_CYCLES-1: frame_err pulse, FSM -> IDLE. The counter saturates and never wraps.
- Decode, evaluated in the cycle of scan_strobe; keycode updates the next cycle:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte is looked up as (ext, byte), then ext and brk are cleared.
- Map, non-ext: 0x1C→0x04, 0x1B→0x16, 0x23→0x07, 0x1D→0x1A, 0x29→0x2C.
- Map, ext: 0x75→0x52, 0x72→0x51, 0x6B→0x50, 0x74→0x4F.
- Unmapped codes: consumed (flags cleared), keycode unchanged, no pulse.
- Make of mapped code M:
  - If keycode ≠ M: keycode <= M and key_valid = 1 in that same cycle.
  - Typematic repeat (keycode == M): no change, no pulse.
- Break of mapped code M: if keycode == M, keycode <= 0; otherwise unchanged. Never pulses key_valid.
- Prefix sequences: E0 F0 xx is an extended break. F0 E0 xx is treated identically.
- Error interaction: frame_err does not clear ext or brk. A new byte always follows its prefix.
- Simultaneous events: a timeout coinciding with a falling edge is resolved as the edge (counter clears, bit accepted).
- Latency: pin edge of the stop bit to keycode update is SYNC_STAGES+3 clk cycles, i.e. 5 at default.

Test Plan:
- Frame 0x23 with correct parity -> scan_strobe once, scan_code = 0x23, keycode = 0x07, key_valid one pulse, frame_err stays 0.
- 0x23 sent again (repeat), then F0 23 -> no second key_valid; keycode returns to 0x00 after the 0x23 byte following F0.
- Frame 0x1D with parity bit inverted -> frame_err one pulse, no scan_strobe, keycode holds its prior value 0x00.
- E0 75 -> keycode = 0x52; then E0 F0 75 -> keycode = 0x00. Unmapped 0x4D -> no keycode change.
- Stop after 4 data bits for TIMEOUT_CYCLES (set 100 in the bench) -> frame_err pulse at cycle 100. A following full 0x1C frame decodes to keycode = 0x04.
- Assert reset after 5 bits of a frame -> all outputs 0 immediately (asynchronous). A fresh 0x1B frame after release -> keycode = 0x16.

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 receiver that turns scan codes into a held HID keycode.
// Stop-bit pin edge to keycode update is SYNC_STAGES+3 clk cycles.
// No backpressure: the keyboard owns the pace, and each output is a one-cycle pulse or level.
module ps2_keycode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       scan_strobe,
    output logic       frame_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   prev_q, fall_q, bit_q;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             scan_q, scan_d;
    logic                   strobe_q, strobe_d;
    logic                   ferr_q, ferr_d;
    logic [7:0]             key_q, key_d;
    logic                   kv_q, kv_d;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic                   timeout;
    logic [8:0]             hit_code;

    function automatic logic [8:0] lookup(input logic ext, input logic [7:0] b);
        logic [8:0] r;
        r = 9'h000;
        if (!ext) begin
            case (b)
                8'h1C:   r = {1'b1, 8'h04};
                8'h1B:   r = {1'b1, 8'h16};
                8'h23:   r = {1'b1, 8'h07};
                8'h1D:   r = {1'b1, 8'h1A};
                8'h29:   r = {1'b1, 8'h2C};
                default: r = 9'h000;
            endcase
        end else begin
            case (b)
                8'h75:   r = {1'b1, 8'h52};
                8'h72:   r = {1'b1, 8'h51};
                8'h6B:   r = {1'b1, 8'h50};
                8'h74:   r = {1'b1, 8'h4F};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    // An edge always wins over a coincident timeout.
    assign timeout = (state_q != IDLE) && !fall_q && (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        scan_d   = scan_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        cnt_d    = cnt_q;
        if (state_q == IDLE || fall_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!bit_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {bit_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = bit_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bit_q && (^{shift_q, par_q})) begin
                        scan_d   = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    assign hit_code = lookup(ext_q, scan_q);

    // Prefix bytes only set flags; the byte after them is the one looked up.
    always_comb begin
        key_d = key_q;
        kv_d  = 1'b0;
        ext_d = ext_q;
        brk_d = brk_q;
        if (strobe_q) begin
            if (scan_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scan_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (hit_code[8]) begin
                    if (brk_q) begin
                        if (key_q == hit_code[7:0]) key_d = 8'h00;
                    end else if (key_q != hit_code[7:0]) begin
                        key_d = hit_code[7:0];
                        kv_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            prev_q      <= 1'b1;
            fall_q      <= 1'b0;
            bit_q       <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            scan_q      <= 8'h00;
            strobe_q    <= 1'b0;
            ferr_q      <= 1'b0;
            key_q       <= 8'h00;
            kv_q        <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            prev_q      <= clk_sync_q[SYNC_STAGES-1];
            fall_q      <= prev_q && !clk_sync_q[SYNC_STAGES-1];
            bit_q       <= data_sync_q[SYNC_STAGES-1];
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            scan_q      <= scan_d;
            strobe_q    <= strobe_d;
            ferr_q      <= ferr_d;
            key_q       <= key_d;
            kv_q        <= kv_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
        end
    end

    assign keycode     = key_q;
    assign key_valid   = kv_q;
    assign scan_code   = scan_q;
    assign scan_strobe = strobe_q;
    assign frame_err   = ferr_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: directed PS/2 frames, expected bytes/keys queued,
// a negedge monitor pops and compares every scan_strobe and key_valid pulse.
module tb_ps2_keycode_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode, scan_code;
    logic       key_valid, scan_strobe, frame_err;

    int checks = 0;
    int errors = 0;
    int exp_ferr = 0;
    int act_ferr = 0;
    logic [7:0] scan_exp_q[$];
    logic [7:0] key_exp_q[$];

    ps2_keycode_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_valid(key_valid), .scan_code(scan_code),
        .scan_strobe(scan_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (scan_strobe) begin
                checks++;
                if (scan_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scan_strobe unexpected actual %02h expected none", scan_code);
                end else begin
                    logic [7:0] e;
                    e = scan_exp_q.pop_front();
                    if (scan_code !== e) begin
                        errors++;
                        $display("FAIL scan_code actual %02h expected %02h", scan_code, e);
                    end
                end
            end
            if (key_valid) begin
                checks++;
                if (key_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL key_valid unexpected actual %02h expected none", keycode);
                end else begin
                    logic [7:0] e;
                    e = key_exp_q.pop_front();
                    if (keycode !== e) begin
                        errors++;
                        $display("FAIL key_valid keycode actual %02h expected %02h", keycode, e);
                    end
                end
            end
            if (frame_err) act_ferr++;
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        repeat (30) @(posedge clk);
    endtask

    task automatic good(input logic [7:0] b);
        scan_exp_q.push_back(b);
        send_frame(b, 1'b0);
    endtask

    task automatic key_is(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, keycode, exp);
    endtask

    initial begin
        int n;
        logic [7:0] part;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset keycode", keycode, 8'h00);
        check("reset scan_code", scan_code, 8'h00);
        check("reset pulses", {5'd0, key_valid, scan_strobe, frame_err}, 8'h00);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        key_exp_q.push_back(8'h07);
        good(8'h23);
        key_is("make 23", 8'h07);
        good(8'h23);
        key_is("repeat 23", 8'h07);
        good(8'hF0);
        key_is("after F0 prefix", 8'h07);
        good(8'h23);
        key_is("break 23", 8'h00);

        exp_ferr++;
        send_frame(8'h1D, 1'b1);
        key_is("bad parity 1D", 8'h00);

        good(8'hE0);
        key_exp_q.push_back(8'h52);
        good(8'h75);
        key_is("ext make 75", 8'h52);
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        key_is("ext break 75", 8'h00);

        key_exp_q.push_back(8'h1A);
        good(8'h1D);
        key_is("make 1D", 8'h1A);
        good(8'h4D);
        key_is("unmapped 4D", 8'h1A);
        good(8'hF0);
        good(8'hE0);
        good(8'h74);
        key_is("F0 E0 74 other key", 8'h1A);

        // Partial frame: start plus four data bits, then the clock stops.
        exp_ferr++;
        part = 8'h0F;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(part[i]);
        ps2_data = part[3];
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (!frame_err && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 10) ps2_clk = 1'b1;
        end
        checks++;
        if (n < 95 || n > 115) begin
            errors++;
            $display("FAIL timeout latency actual %0d expected 95..115", n);
        end
        repeat (20) @(posedge clk);
        key_exp_q.push_back(8'h04);
        good(8'h1C);
        key_is("make 1C after timeout", 8'h04);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        #1;
        check("midreset keycode", keycode, 8'h00);
        check("midreset scan_code", scan_code, 8'h00);
        check("midreset pulses", {5'd0, key_valid, scan_strobe, frame_err}, 8'h00);
        repeat (3) @(posedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        key_exp_q.push_back(8'h16);
        good(8'h1B);
        key_is("make 1B after reset", 8'h16);

        repeat (20) @(posedge clk);
        check("scan queue drained", 8'(scan_exp_q.size()), 8'd0);
        check("key queue drained", 8'(key_exp_q.size()), 8'd0);
        check("frame_err count", 8'(act_ferr), 8'(exp_ferr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
